// File: rtl/sorter_ingress_4x8b.sv
// Ingress buffer for the 4x8b bitonic sorter: gathers four bytes into slots, then hands the group on with val/rdy.
// Optional flush of a partial group, padded with PAD_VALUE, when SORTER_INGRESS_FLUSH_EN is defined.
module sorter_ingress_4x8b #(
   parameter logic [7:0] PAD_VALUE = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_val,
   output logic       in_rdy,
   input  logic [7:0] in_msg,
   output logic       out_val,
   input  logic       out_rdy,
   output logic [7:0] out0,
   output logic [7:0] out1,
   output logic [7:0] out2,
   output logic [7:0] out3,
   output logic [2:0] count
`ifdef SORTER_INGRESS_FLUSH_EN
   ,
   input  logic       flush
`endif
);

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned CW = 3;

   typedef enum logic {FILL, FULL} state_t;

   state_t          state, state_nxt;
   logic [W-1:0]    slot     [N];
   logic [W-1:0]    slot_nxt [N];
   logic [CW-1:0]   count_nxt;
   logic            out_val_nxt;
   logic            in_xfer;
   logic            out_xfer;
   logic            flush_on;

`ifdef SORTER_INGRESS_FLUSH_EN
   assign flush_on = flush;
`else
   logic unused_pad;
   assign unused_pad = ^PAD_VALUE;
   assign flush_on   = 1'b0;
`endif

   // A full group only frees its slots when the consumer takes it, so in_rdy follows out_rdy there.
   assign in_rdy   = !reset && ((state == FILL) || out_rdy);
   assign in_xfer  = in_val && in_rdy;
   assign out_xfer = out_val && out_rdy;

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      slot_nxt    = slot;
      out_val_nxt = out_val;
      case (state)
         FILL: begin
            if (in_xfer) begin
               slot_nxt[count[1:0]] = in_msg;
               count_nxt            = count + 3'd1;
            end
         end
         FULL: begin
            if (out_xfer) begin
               count_nxt = 3'd0;
               if (in_xfer) begin
                  slot_nxt[0] = in_msg;
                  count_nxt   = 3'd1;
               end
            end
         end
         default: ;
      endcase
      // Flush closes a partial group after this cycle's word, padding the unused slots.
      if (flush_on && (count_nxt != 3'd0) && (count_nxt != CW'(N))) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (CW'(i) >= count_nxt) slot_nxt[i] = PAD_VALUE;
         end
         count_nxt = CW'(N);
      end
      state_nxt   = (count_nxt == CW'(N)) ? FULL : FILL;
      out_val_nxt = (count_nxt == CW'(N));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FILL;
         count   <= '0;
         out_val <= 1'b0;
         for (int unsigned i = 0; i < N; i++) slot[i] <= '0;
      end else begin
         state   <= state_nxt;
         count   <= count_nxt;
         out_val <= out_val_nxt;
         for (int unsigned i = 0; i < N; i++) slot[i] <= slot_nxt[i];
      end
   end

   assign out0 = slot[0];
   assign out1 = slot[1];
   assign out2 = slot[2];
   assign out3 = slot[3];

endmodule

// File: tb/tb_sorter_ingress_4x8b.sv
// Bench for sorter_ingress_4x8b: vector table, hand sequences and a random run against a queue model.
module tb_sorter_ingress_4x8b;

   localparam logic [7:0] PAD = 8'hFF;

   logic       clk = 1'b0;
   logic       reset, in_val, in_rdy, out_val, out_rdy;
   logic [7:0] in_msg, out0, out1, out2, out3;
   logic [2:0] count;
`ifdef SORTER_INGRESS_FLUSH_EN
   logic       flush = 1'b0;
`endif

   sorter_ingress_4x8b #(.PAD_VALUE(PAD)) dut (
      .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
      .out_val(out_val), .out_rdy(out_rdy), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
      .count(count)
`ifdef SORTER_INGRESS_FLUSH_EN
      , .flush(flush)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_out  = 0;

   logic [7:0] m_q[$];
   bit         m_full = 1'b0;
   bit         m_chk  = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   // One clock: drive at negedge, check handshake before the edge, update model, check state after it.
   task automatic tick(input logic r, input logic v, input logic [7:0] m, input logic o);
      logic m_rdy;
      @(negedge clk);
      reset = r; in_val = v; in_msg = m; out_rdy = o;
      #1;
      m_rdy = !r && (!m_full || o);
      if (m_chk) chk("in_rdy_pre", 32'(in_rdy), 32'(m_rdy));
      if (out_val && out_rdy) n_out++;
      @(posedge clk);
      if (r) begin
         m_q.delete();
         m_full = 1'b0;
      end else begin
         if (m_full && o) begin
            m_q.delete();
            m_full = 1'b0;
         end
         if (v && m_rdy) m_q.push_back(m);
`ifdef SORTER_INGRESS_FLUSH_EN
         if (flush && m_q.size() > 0 && m_q.size() < 4)
            while (m_q.size() < 4) m_q.push_back(PAD);
`endif
         if (m_q.size() == 4) m_full = 1'b1;
      end
      #1;
      if (m_chk) begin
         chk("count", 32'(count), 32'(m_q.size()));
         chk("out_val", 32'(out_val), 32'(m_full));
         if (m_full) chk("group", {out0, out1, out2, out3}, {m_q[0], m_q[1], m_q[2], m_q[3]});
      end
   endtask

   typedef struct {
      logic        rst, val;
      logic [7:0]  msg;
      logic        ordy;
      logic        ov;
      logic [2:0]  cnt;
      logic        rdy;
      logic        dchk;
      logic [31:0] data;
   } vec_t;

   vec_t tbl[19];

   initial begin
      logic [31:0] held;
      reset = 1'b1; in_val = 1'b0; in_msg = 8'h00; out_rdy = 1'b0;

      //             rst  val  msg    ordy ov   cnt   rdy  dchk data
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00000000};
      tbl[1]  = '{1'b0, 1'b1, 8'h30, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 1'b1, 8'h10, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0};
      tbl[4]  = '{1'b0, 1'b1, 8'h20, 1'b1, 1'b1, 3'd4, 1'b1, 1'b1, 32'h30104020};
      tbl[5]  = '{1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'h30104020};
      tbl[6]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};
      tbl[7]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0};
      tbl[9]  = '{1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0};
      tbl[10] = '{1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0};
      tbl[11] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0};
      tbl[12] = '{1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 32'h0};
      tbl[13] = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 32'hA1A2A3A4};
      tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00000000};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};
      tbl[16] = '{1'b0, 1'b1, 8'hB1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 32'h0};
      tbl[17] = '{1'b0, 1'b1, 8'hB2, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 32'h0};
      tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 32'h00000000};

      for (int i = 0; i < 19; i++) begin
         tick(tbl[i].rst, tbl[i].val, tbl[i].msg, tbl[i].ordy);
         chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("tbl%0d_out_val", i), 32'(out_val), 32'(tbl[i].ov));
         chk($sformatf("tbl%0d_in_rdy", i), 32'(in_rdy), 32'(tbl[i].rdy));
         if (tbl[i].dchk)
            chk($sformatf("tbl%0d_slots", i), {out0, out1, out2, out3}, tbl[i].data);
      end

      // 12-word stream at full rate: three groups, no idle cycle.
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      n_out = 0;
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 8'(i * 17 + 3), 1'b1);
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      chk("stream_groups", 32'(n_out), 32'd3);

      // Backpressure: hold full group five cycles with a pending word, then release.
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
      held = {out0, out1, out2, out3};
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b1, 8'h77, 1'b0);
         chk("bp_in_rdy", 32'(in_rdy), 32'd0);
         chk("bp_stable", {out0, out1, out2, out3}, held);
      end
      tick(1'b0, 1'b1, 8'h77, 1'b1);
      chk("bp_release_count", 32'(count), 32'd1);
      chk("bp_release_slot0", 32'(out0), 32'h77);

`ifdef SORTER_INGRESS_FLUSH_EN
      tick(1'b1, 1'b0, 8'h00, 1'b1);
      tick(1'b0, 1'b1, 8'h05, 1'b1);
      tick(1'b0, 1'b1, 8'h07, 1'b1);
      flush = 1'b1;
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      flush = 1'b0;
      chk("flush_group", {out0, out1, out2, out3}, 32'h0507FFFF);
      chk("flush_out_val", 32'(out_val), 32'd1);
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      flush = 1'b1;
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      flush = 1'b0;
      chk("flush_empty_count", 32'(count), 32'd0);
      chk("flush_empty_out_val", 32'(out_val), 32'd0);
      for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
      flush = 1'b1;
      tick(1'b0, 1'b1, 8'h99, 1'b1);
      flush = 1'b0;
      chk("flush_full_group", {out0, out1, out2, out3}, 32'h99FFFFFF);
      chk("flush_full_count", 32'(count), 32'd4);
`endif

      // Random traffic against the queue model.
      for (int i = 0; i < 600; i++) begin
`ifdef SORTER_INGRESS_FLUSH_EN
         flush = ($urandom_range(0, 7) == 0);
`endif
         tick(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
              8'($urandom_range(0, 255)), ($urandom_range(0, 9) < 6));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
